// File: rtl/proc_run_controller.sv
// Front-end sequencer for the image Processor core: debounces buttons,
// issues one command per press, waits for completion, then dumps the bytes.
module proc_run_controller #(
   parameter int DEB_CYCLES = 4,
   parameter int ADDR_W     = 8,
   parameter int LAST_ADDR  = 255,
   parameter int TIMEOUT    = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        btn_raw,
   input  logic              proc_done,
   input  logic [7:0]        rd_data,
   output logic [2:0]        proc_btn,
   output logic [ADDR_W-1:0] proc_bytePos,
   output logic              dump_valid,
   output logic [7:0]        dump_data,
   input  logic              dump_ready,
   output logic              busy,
   output logic              err
);
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      FETCH,
      SEND
   } state_t;

   state_t state;
   state_t nextState;

   logic [2:0]        syncA;
   logic [2:0]        syncB;
   logic [2:0]        debLvl;
   logic [2:0]        debPrev;
   logic [2:0]        press;
   logic [DW-1:0]     debCnt [0:2];
   logic [2:0]        op;
   logic [2:0]        opNext;
   logic [ADDR_W-1:0] addr;
   logic [WW-1:0]     waitCnt;
   logic              waitExpired;
   logic              lastByte;
   logic              handshake;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncA <= '0;
         syncB <= '0;
      end else begin
         syncA <= btn_raw;
         syncB <= syncA;
      end
   end

   // Level only flips after DEB_CYCLES straight disagreeing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         debLvl  <= '0;
         debPrev <= '0;
         for (int i = 0; i < 3; i++) begin
            debCnt[i] <= '0;
         end
      end else begin
         debPrev <= debLvl;
         for (int i = 0; i < 3; i++) begin
            if (syncB[i] == debLvl[i]) begin
               debCnt[i] <= '0;
            end else if (debCnt[i] == DW'(DEB_CYCLES - 1)) begin
               debLvl[i] <= syncB[i];
               debCnt[i] <= '0;
            end else begin
               debCnt[i] <= debCnt[i] + DW'(1);
            end
         end
      end
   end

   assign press = debLvl & ~debPrev;

   always_comb begin
      opNext = 3'b000;
      priority case (1'b1)
         press[2]: opNext = 3'b100;
         press[1]: opNext = 3'b010;
         press[0]: opNext = 3'b001;
         default:  opNext = 3'b000;
      endcase
   end

   assign waitExpired = (waitCnt == WW'(TIMEOUT - 1));
   assign lastByte    = (addr == ADDR_W'(LAST_ADDR));
   assign handshake   = (state == SEND) && dump_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (|press) nextState = ISSUE;
         end
         ISSUE: begin
            nextState = WAIT;
         end
         WAIT: begin
            if (proc_done) nextState = FETCH;
            else if (waitExpired) nextState = IDLE;
         end
         FETCH: begin
            nextState = SEND;
         end
         SEND: begin
            if (handshake) nextState = lastByte ? IDLE : FETCH;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op        <= '0;
         addr      <= '0;
         waitCnt   <= '0;
         dump_data <= '0;
         err       <= 1'b0;
      end else begin
         if ((state == IDLE) && (|press)) begin
            op <= opNext;
         end
         if (state == ISSUE) begin
            waitCnt <= '0;
         end else if (state == WAIT) begin
            waitCnt <= waitCnt + WW'(1);
         end
         if ((state == WAIT) && proc_done) begin
            addr <= '0;
         end else if (handshake && !lastByte) begin
            addr <= addr + ADDR_W'(1);
         end
         // Core data is valid by the end of the FETCH cycle.
         if (state == FETCH) begin
            dump_data <= rd_data;
         end
         if ((state == WAIT) && waitExpired && !proc_done) begin
            err <= 1'b1;
         end
      end
   end

   always_comb begin
      proc_btn     = '0;
      proc_bytePos = '0;
      dump_valid   = 1'b0;
      busy         = 1'b1;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
         end
         ISSUE: begin
            proc_btn = op;
         end
         WAIT: begin
            proc_btn = '0;
         end
         FETCH: begin
            proc_bytePos = addr;
         end
         SEND: begin
            proc_bytePos = addr;
            dump_valid   = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end
endmodule
